// File: rtl/mdu_core.sv
// mdu_core: E-stage multiply/divide unit owning HI/LO with a fixed-latency busy window.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 9/10); otherwise they decode as NONE.
module mdu_core #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        cancel,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] rd,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4,
                          OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD = 4'd9, OP_MADDU = 4'd10;
`endif
   typedef enum logic {IDLE, BUSY} state_e;
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;
   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s;
   logic accept;
   assign accept = start & ~cancel & (state_q == IDLE);
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'b0, a} * {32'b0, b};
   // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
   assign abs_a = a[31] ? -a : a;
   assign abs_b = b[31] ? -b : b;
   assign q_mag = abs_a / abs_b;
   assign r_mag = abs_a % abs_b;
   assign q_s   = (a[31] ^ b[31]) ? -q_mag : q_mag;
   assign r_s   = a[31] ? -r_mag : r_mag;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      p_hi_d  = p_hi_q;
      p_lo_d  = p_lo_q;
      if (state_q == BUSY) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            hi_d    = p_hi_q;
            lo_d    = p_lo_q;
            state_d = IDLE;
         end
      end else if (accept) begin
         case (op)
            OP_MULT: begin
               {p_hi_d, p_lo_d} = prod_s;
               cnt_d   = CW'(MULT_CYCLES);
               state_d = BUSY;
            end
            OP_MULTU: begin
               {p_hi_d, p_lo_d} = prod_u;
               cnt_d   = CW'(MULT_CYCLES);
               state_d = BUSY;
            end
            OP_DIV: begin
               p_hi_d  = (b == 32'd0) ? hi_q : r_s;
               p_lo_d  = (b == 32'd0) ? lo_q : q_s;
               cnt_d   = CW'(DIV_CYCLES);
               state_d = BUSY;
            end
            OP_DIVU: begin
               p_hi_d  = (b == 32'd0) ? hi_q : a % b;
               p_lo_d  = (b == 32'd0) ? lo_q : a / b;
               cnt_d   = CW'(DIV_CYCLES);
               state_d = BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            OP_MADD: begin
               {p_hi_d, p_lo_d} = {hi_q, lo_q} + prod_s;
               cnt_d   = CW'(MULT_CYCLES);
               state_d = BUSY;
            end
            OP_MADDU: begin
               {p_hi_d, p_lo_d} = {hi_q, lo_q} + prod_u;
               cnt_d   = CW'(MULT_CYCLES);
               state_d = BUSY;
            end
`endif
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
      end
   end
   assign busy = (state_q == BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign rd   = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: randomized self-checking bench for mdu_core against an arithmetic HI/LO model.
module tb_mdu_core;
   localparam int MC = 5;
   localparam int DC = 10;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic cancel = 1'b0;
   logic [3:0] op = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic busy;
   logic [31:0] rd, hi, lo;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;
   int vectors = 0;
   int miscompares = 0;
   mdu_core #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cancel(cancel), .op(op),
      .a(a), .b(b), .busy(busy), .rd(rd), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic c);
      int n;
      logic [31:0] eh, el, erd;
      logic [63:0] res;
      longint sx, sy;
      longint unsigned ux, uy;
      eh = hi_m;
      el = lo_m;
      n = 0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      erd = (o == 4'd5) ? hi_m : (o == 4'd6) ? lo_m : 32'd0;
      if (!c) begin
         case (o)
            4'd1: begin res = 64'(sx * sy); {eh, el} = res; n = MC; end
            4'd2: begin res = ux * uy; {eh, el} = res; n = MC; end
            4'd3: begin
               if (y != 0) begin el = 32'(sx / sy); eh = 32'(sx % sy); end
               n = DC;
            end
            4'd4: begin
               if (y != 0) begin el = 32'(ux / uy); eh = 32'(ux % uy); end
               n = DC;
            end
            4'd7: eh = x;
            4'd8: el = x;
`ifdef MDU_MADD_EN
            4'd9: begin res = {hi_m, lo_m} + 64'(sx * sy); {eh, el} = res; n = MC; end
            4'd10: begin res = {hi_m, lo_m} + ux * uy; {eh, el} = res; n = MC; end
`endif
            default: ;
         endcase
      end
      @(negedge clk);
      start = 1'b1; cancel = c; op = o; a = x; b = y;
      #1;
      vectors++;
      if (rd !== erd) begin
         miscompares++;
         $display("FAIL rd op=%0d: got %h expected %h", o, rd, erd);
      end
      @(posedge clk);
      #1;
      start = 1'b0; cancel = 1'b0; op = 4'd0;
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (busy !== 1'b1 || hi !== hi_m || lo !== lo_m) begin
            miscompares++;
            $display("FAIL busy_window op=%0d cyc=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                     o, i, busy, hi, lo, hi_m, lo_m);
         end
         @(posedge clk);
         #1;
      end
      vectors++;
      if (busy !== 1'b0 || hi !== eh || lo !== el) begin
         miscompares++;
         $display("FAIL result op=%0d a=%h b=%h: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                  o, x, y, busy, hi, lo, eh, el);
      end
      hi_m = eh;
      lo_m = el;
   endtask
   task automatic test_reset();
      #12;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || rd !== 32'd0) begin
         miscompares++;
         $display("FAIL reset: busy=%b hi=%h lo=%h rd=%h expected all zero", busy, hi, lo, rd);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask
   task automatic test_mult();
      do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      do_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
      for (int i = 0; i < 6; i++) do_op(4'($urandom_range(1, 2)), $urandom, $urandom, 1'b0);
   endtask
   task automatic test_div();
      do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      do_op(4'd4, 32'd7, 32'd2, 1'b0);
      do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      do_op(4'd7, 32'h11, 32'd0, 1'b0);
      do_op(4'd8, 32'h22, 32'd0, 1'b0);
      do_op(4'd3, 32'h1234, 32'd0, 1'b0);
      do_op(4'd4, 32'h1234, 32'd0, 1'b0);
      for (int i = 0; i < 6; i++) do_op(4'($urandom_range(3, 4)), $urandom, $urandom, 1'b0);
   endtask
   task automatic test_move();
      do_op(4'd8, 32'hABCD, 32'd0, 1'b0);
      do_op(4'd6, 32'd0, 32'd0, 1'b0);
      do_op(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
      do_op(4'd5, 32'd0, 32'd0, 1'b0);
   endtask
   task automatic test_cancel();
      do_op(4'd1, 32'd1234, 32'd5678, 1'b1);
      do_op(4'd7, 32'h5555, 32'd0, 1'b1);
      do_op(4'd3, 32'd100, 32'd7, 1'b1);
   endtask
   task automatic test_async_reset();
      do_op(4'd7, 32'h77, 32'd0, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0; op = 4'd0;
      repeat (7) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL async_reset: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
      end
      @(negedge clk);
      reset_n = 1'b1;
      hi_m = '0;
      lo_m = '0;
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL no_late_writeback: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
      end
   endtask
   task automatic test_madd();
      do_op(4'd7, 32'd0, 32'd0, 1'b0);
      do_op(4'd8, 32'hFFFFFFFF, 32'd0, 1'b0);
      do_op(4'd10, 32'd1, 32'd1, 1'b0);
      do_op(4'd9, 32'hFFFFFFFF, 32'd3, 1'b0);
      do_op(4'd10, $urandom, $urandom, 1'b0);
   endtask
   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++)
         do_op(4'($urandom_range(0, 10)), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
               ($urandom_range(0, 9) == 0));
   endtask
   initial begin
      test_reset();
      test_mult();
      test_div();
      test_move();
      test_cancel();
      test_async_reset();
      test_madd();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
